// File: rtl/fpga_reload_ctrl.sv
// fpga_reload_ctrl
// Slow-control driven FPGA reconfiguration sequencer. A reload needs an ARM write with ARM_KEY
// followed by a FIRE write with FIRE_KEY. A countdown of DELAY cycles then runs, after which
// FPGAReload is held high for PULSE_LEN cycles. A single corrupted write therefore cannot
// trigger a reboot. The block also answers status reads on its own SC port.
//
// Ports:
//   clk, reset                 system clock; asynchronous active-high reset
//   sc_port/addr/data/subaddr  SC request fields (subaddr ignored)
//   sc_op, sc_frame, sc_wr     SC op (must be 0); frame (rising edge = request); write enable
//   sc_ack                     one-cycle reply strobe, two cycles after the request cycle
//   sc_rply_data/error         reply payload, held until the next ack
//   FPGAReload                 registered reload request, high only in PULSE
//   reload_state               current FSM state (IDLE=0, ARMED=1, COUNT=2, PULSE=3)
module fpga_reload_ctrl #(
    parameter logic [15:0] RELOAD_PORT   = 16'h2778,
    parameter logic [31:0] ARM_KEY       = 32'h5A5AA5A5,
    parameter logic [31:0] FIRE_KEY      = 32'hDEADBEEF,
    parameter logic [31:0] ARM_TIMEOUT   = 32'd125000000,
    parameter logic [31:0] DEFAULT_DELAY = 32'd12500000,
    parameter logic [31:0] PULSE_LEN     = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sc_port,
    input  logic [31:0] sc_data,
    input  logic [31:0] sc_addr,
    input  logic [31:0] sc_subaddr,
    input  logic        sc_op,
    input  logic        sc_frame,
    input  logic        sc_wr,
    output logic        sc_ack,
    output logic [31:0] sc_rply_data,
    output logic [31:0] sc_rply_error,
    output logic        FPGAReload,
    output logic [1:0]  reload_state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StCount = 2'd2,
        StPulse = 2'd3
    } state_e;

    localparam logic [31:0] AddrArm    = 32'd0;
    localparam logic [31:0] AddrFire   = 32'd1;
    localparam logic [31:0] AddrDelay  = 32'd2;
    localparam logic [31:0] AddrStatus = 32'd3;

    localparam logic [31:0] ErrOk     = 32'd0;
    localparam logic [31:0] ErrAddr   = 32'd1;
    localparam logic [31:0] ErrKey    = 32'd2;
    localparam logic [31:0] ErrState  = 32'd3;
    localparam logic [31:0] ErrAccess = 32'd4;
    localparam logic [31:0] ErrOp     = 32'd5;

    state_e      state_q, state_d;
    logic [31:0] arm_cnt_q, arm_cnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0] delay_q, delay_d;
    logic        sticky_q, sticky_d;
    logic        frame_q;
    logic        pend_q, pend_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] pend_err_q, pend_err_d;
    logic        sc_ack_q;
    logic [31:0] rply_data_q, rply_err_q;
    logic        reload_q;
    logic        req;
    logic        timeout_now;
    logic        unused_subaddr;

    assign unused_subaddr = ^sc_subaddr;

    // Requests are ignored while the previous one is still in its reply pipeline.
    assign req = sc_frame && !frame_q && (sc_port == RELOAD_PORT) && !pend_q && !sc_ack_q;
    assign timeout_now = (state_q == StArmed) && (arm_cnt_q == ARM_TIMEOUT - 32'd1);

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        count_d     = count_q;
        pulse_cnt_d = pulse_cnt_q;
        delay_d     = delay_q;
        sticky_d    = sticky_q;
        pend_d      = 1'b0;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;

        // Autonomous progression; an accepted command below overrides it.
        unique case (state_q)
            StIdle: begin
            end
            StArmed: begin
                if (timeout_now) begin
                    state_d   = StIdle;
                    arm_cnt_d = '0;
                    sticky_d  = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 32'd1;
                end
            end
            StCount: begin
                if (count_q == '0) begin
                    state_d     = StPulse;
                    pulse_cnt_d = '0;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            StPulse: begin
                if (pulse_cnt_q == PULSE_LEN - 32'd1) begin
                    state_d     = StIdle;
                    pulse_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 32'd1;
                end
            end
            default: begin
            end
        endcase

        if (req) begin
            pend_d      = 1'b1;
            pend_data_d = '0;
            pend_err_d  = ErrOk;
            if (sc_op) begin
                pend_err_d = ErrOp;
            end else begin
                case (sc_addr)
                    AddrArm: begin
                        if (!sc_wr) begin
                            pend_err_d = ErrAccess;
                        end else if (state_q == StIdle || state_q == StArmed) begin
                            if (sc_data == ARM_KEY) begin
                                // Re-arming also cancels a timeout landing on this cycle.
                                state_d     = StArmed;
                                arm_cnt_d   = '0;
                                sticky_d    = sticky_q;
                                pend_data_d = sc_data;
                            end else begin
                                pend_err_d = ErrKey;
                            end
                        end else begin
                            pend_err_d = ErrState;
                        end
                    end
                    AddrFire: begin
                        if (!sc_wr) begin
                            pend_err_d = ErrAccess;
                        end else begin
                            unique case (state_q)
                                StIdle: pend_err_d = ErrState;
                                StArmed: begin
                                    arm_cnt_d = '0;
                                    sticky_d  = sticky_q;
                                    if (sc_data == FIRE_KEY) begin
                                        state_d     = StCount;
                                        count_d     = delay_q;
                                        pend_data_d = sc_data;
                                    end else begin
                                        state_d    = StIdle;
                                        pend_err_d = ErrKey;
                                    end
                                end
                                StCount: begin
                                    // Any FIRE during the countdown aborts it.
                                    state_d     = StIdle;
                                    count_d     = '0;
                                    pend_data_d = sc_data;
                                end
                                StPulse: pend_err_d = ErrState;
                                default: pend_err_d = ErrState;
                            endcase
                        end
                    end
                    AddrDelay: begin
                        if (sc_wr) begin
                            delay_d     = sc_data;
                            pend_data_d = sc_data;
                        end else begin
                            pend_data_d = delay_q;
                        end
                    end
                    AddrStatus: begin
                        if (sc_wr) begin
                            pend_err_d = ErrAccess;
                        end else begin
                            pend_data_d = {28'b0, sticky_q, 1'b0, state_q};
                            // A timeout on the same cycle re-sets the flag.
                            sticky_d    = timeout_now;
                        end
                    end
                    default: pend_err_d = ErrAddr;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            arm_cnt_q   <= '0;
            count_q     <= '0;
            pulse_cnt_q <= '0;
            delay_q     <= DEFAULT_DELAY;
            sticky_q    <= 1'b0;
            frame_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_err_q  <= '0;
            sc_ack_q    <= 1'b0;
            rply_data_q <= '0;
            rply_err_q  <= '0;
            reload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            count_q     <= count_d;
            pulse_cnt_q <= pulse_cnt_d;
            delay_q     <= delay_d;
            sticky_q    <= sticky_d;
            frame_q     <= sc_frame;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            sc_ack_q    <= pend_q;
            if (pend_q) begin
                rply_data_q <= pend_data_q;
                rply_err_q  <= pend_err_q;
            end
            reload_q    <= (state_d == StPulse);
        end
    end

    assign sc_ack        = sc_ack_q;
    assign sc_rply_data  = rply_data_q;
    assign sc_rply_error = rply_err_q;
    assign FPGAReload    = reload_q;
    assign reload_state  = state_q;

endmodule
